// File: rtl/game_pkg.sv
// Shared phase encodings, widths and default durations for the game sequencer.
// Optional pause feature is built in when GAME_PAUSE_EN is defined.
package game_pkg;

    localparam int PH_W  = 3;
    localparam int SEC_W = 7;

    localparam logic [PH_W-1:0] PH_OPEN = 3'd0;
    localparam logic [PH_W-1:0] PH_CD3  = 3'd1;
    localparam logic [PH_W-1:0] PH_CD2  = 3'd2;
    localparam logic [PH_W-1:0] PH_CD1  = 3'd3;
    localparam logic [PH_W-1:0] PH_PLAY = 3'd4;
    localparam logic [PH_W-1:0] PH_OVER = 3'd5;

    localparam int DEF_TICK_DIV  = 100_000_000;
    localparam int DEF_OPEN_SECS = 4;
    localparam int DEF_CD_SECS   = 1;
    localparam int DEF_GAME_SECS = 120;

    // Phase order; OVER loops back to the opening screen.
    function automatic logic [PH_W-1:0] phase_next(
        input logic [PH_W-1:0] ph
    );
        case (ph)
            PH_OPEN: return PH_CD3;
            PH_CD3:  return PH_CD2;
            PH_CD2:  return PH_CD1;
            PH_CD1:  return PH_PLAY;
            PH_PLAY: return PH_OVER;
            default: return PH_OPEN;
        endcase
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1, freezes on hold, restarts on clr.
// tick is the wrap cycle; sec_tick is its registered copy for the outside world.
module sec_prescaler
    import game_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick,
    output logic sec_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic          r_sec_tick;

    assign tick     = !hold && (r_pre == LAST);
    assign sec_tick = r_sec_tick;

    // Prescale counter: restart on clr, freeze on hold, wrap at LAST.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (hold) begin
            r_pre <= r_pre;
        end else if (tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Registered one-cycle second pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= tick;
        end
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// Game sequencer: OPEN -> CD3/CD2/CD1 -> PLAY -> OVER, committed on frame_start.
// Define GAME_PAUSE_EN to let pause freeze the play timer.
module game_phase_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int OPEN_SECS = DEF_OPEN_SECS,
    parameter int CD_SECS   = DEF_CD_SECS,
    parameter int GAME_SECS = DEF_GAME_SECS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             start_req,
    input  logic             pause,
    output logic [PH_W-1:0]  phase,
    output logic             num_en,
    output logic             play_en,
    output logic             game_over,
    output logic             sec_tick,
    output logic [SEC_W-1:0] secs_left
);

    localparam logic [SEC_W-1:0] OPEN_D = SEC_W'(OPEN_SECS);
    localparam logic [SEC_W-1:0] CD_D   = SEC_W'(CD_SECS);
    localparam logic [SEC_W-1:0] GAME_D = SEC_W'(GAME_SECS);

    logic [PH_W-1:0]  r_phase;
    logic [SEC_W-1:0] r_sec;
    logic             r_pend;
    logic             r_num_en;
    logic             r_play_en;
    logic             r_game_over;
    logic [SEC_W-1:0] r_secs_left;

    logic [PH_W-1:0]  w_phase_nxt;
    logic [SEC_W-1:0] w_sec_nxt;
    logic             w_pend_nxt;
    logic [SEC_W-1:0] w_dur;
    logic [SEC_W-1:0] w_sec_inc;
    logic             w_tick;
    logic             w_hold;
    logic             w_paused;
    logic             w_expire;
    logic             w_start;
    logic             w_event;
    logic             w_commit;
    logic             w_num_en;
    logic             w_play_en;
    logic             w_game_over;
    logic [SEC_W-1:0] w_secs_left;

`ifdef GAME_PAUSE_EN
    assign w_paused = pause && (r_phase == PH_PLAY) && !r_pend;
`else
    // pause is a don't-care in this build.
    assign w_paused = pause & 1'b0;
`endif

    assign w_hold    = r_pend || w_paused;
    assign w_sec_inc = r_sec + SEC_W'(1);
    assign w_expire  = w_tick && (r_phase != PH_OVER) && (w_sec_inc == w_dur);
    assign w_start   = start_req && !r_pend &&
                       ((r_phase == PH_OPEN) || (r_phase == PH_OVER));
    assign w_event   = w_expire || w_start;
    assign w_commit  = frame_start && (r_pend || w_event);

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_pre (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_commit),
        .hold     (w_hold),
        .tick     (w_tick),
        .sec_tick (sec_tick)
    );

    // Duration of the current phase in seconds.
    always_comb begin
        w_dur = '0;
        case (r_phase)
            PH_OPEN:                w_dur = OPEN_D;
            PH_CD3, PH_CD2, PH_CD1: w_dur = CD_D;
            PH_PLAY:                w_dur = GAME_D;
            default:                w_dur = '0;
        endcase
    end

    // State register: phase, seconds-in-phase and pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_OPEN;
            r_sec   <= '0;
            r_pend  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_sec   <= w_sec_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next state: commit on a frame boundary, else count and latch expiry.
    always_comb begin
        w_phase_nxt = r_phase;
        w_sec_nxt   = r_sec;
        w_pend_nxt  = r_pend;
        if (w_commit) begin
            w_phase_nxt = phase_next(r_phase);
            w_sec_nxt   = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            if (w_tick) begin
                w_sec_nxt = w_sec_inc;
            end
            if (w_event) begin
                w_pend_nxt = 1'b1;
            end
        end
    end

    // Output decode from the next state so outputs move on the commit edge.
    always_comb begin
        w_num_en    = (w_phase_nxt == PH_CD3) || (w_phase_nxt == PH_CD2) ||
                      (w_phase_nxt == PH_CD1);
        w_play_en   = (w_phase_nxt == PH_PLAY) && !w_paused;
        w_game_over = (w_phase_nxt == PH_OVER);
        w_secs_left = GAME_D;
        if (w_phase_nxt == PH_OVER) begin
            w_secs_left = '0;
        end else if (w_phase_nxt == PH_PLAY) begin
            w_secs_left = GAME_D - w_sec_nxt;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_en    <= 1'b0;
            r_play_en   <= 1'b0;
            r_game_over <= 1'b0;
            r_secs_left <= GAME_D;
        end else begin
            r_num_en    <= w_num_en;
            r_play_en   <= w_play_en;
            r_game_over <= w_game_over;
            r_secs_left <= w_secs_left;
        end
    end

    assign phase     = r_phase;
    assign num_en    = r_num_en;
    assign play_en   = r_play_en;
    assign game_over = r_game_over;
    assign secs_left = r_secs_left;

endmodule
